// File: rtl/aes128_round_sequencer.sv
// rtl/aes128_round_sequencer.sv - AES-128 encryption sequencer driving an external shared round datapath
module aes128_round_sequencer #(
  parameter int NUM_ROUNDS    = 10,
  parameter int ROUND_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] cipher_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic         err,
  output logic [3:0]   round_idx,
  output logic [127:0] rnd_data_in,
  output logic [127:0] rnd_key,
  output logic         rnd_i_en,
  output logic         rnd_skip_mix_cols,
  input  logic [127:0] rnd_data_out,
  input  logic         rnd_o_en
);

  localparam int CW = $clog2(ROUND_TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_KEYGEN, S_ISSUE, S_WAIT, S_DONE} fsm_t;

  fsm_t          fsm_state, fsm_next;
  logic [127:0]  state_reg, key_reg;
  logic [3:0]    round_cnt;
  logic [CW-1:0] wait_cnt;
  logic          err_q;
  logic          last_round, timeout;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s, r;
    s = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    w0 = k[127:96] ^ t ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign last_round = (round_cnt == 4'(NUM_ROUNDS));
  assign timeout    = (wait_cnt == CW'(ROUND_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) fsm_state <= S_IDLE;
    else     fsm_state <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm_state;
    case (fsm_state)
      S_IDLE:   if (in_valid) fsm_next = S_KEYGEN;
      S_KEYGEN: fsm_next = S_ISSUE;
      S_ISSUE:  fsm_next = S_WAIT;
      S_WAIT: begin
        if (rnd_o_en)     fsm_next = last_round ? S_DONE : S_KEYGEN;
        else if (timeout) fsm_next = S_IDLE;
      end
      S_DONE:   if (out_ready) fsm_next = S_IDLE;
      default:  fsm_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready          = 1'b0;
    busy              = 1'b1;
    out_valid         = 1'b0;
    ciphertext        = '0;
    rnd_i_en          = 1'b0;
    rnd_skip_mix_cols = 1'b0;
    case (fsm_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_ISSUE: begin
        rnd_i_en          = 1'b1;
        rnd_skip_mix_cols = last_round;
      end
      S_WAIT:  rnd_skip_mix_cols = last_round;
      S_DONE: begin
        out_valid  = 1'b1;
        ciphertext = state_reg;
      end
      default: ;
    endcase
  end

  assign rnd_data_in = state_reg;
  assign rnd_key     = key_reg;
  assign round_idx   = round_cnt;
  assign err         = err_q;

  // round_cnt returns to 0 whenever the FSM heads back to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      key_reg   <= '0;
      round_cnt <= '0;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (fsm_state)
        S_IDLE: begin
          if (in_valid) begin
            state_reg <= plaintext ^ cipher_key;
            key_reg   <= cipher_key;
            round_cnt <= 4'd1;
          end
        end
        S_KEYGEN: key_reg  <= expand_key(key_reg, rcon(round_cnt));
        S_ISSUE:  wait_cnt <= '0;
        S_WAIT: begin
          if (rnd_o_en) begin
            state_reg <= rnd_data_out;
            if (!last_round) round_cnt <= round_cnt + 4'd1;
          end else if (timeout) begin
            err_q     <= 1'b1;
            round_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DONE:   if (out_ready) round_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// tb/tb_aes128_round_sequencer.sv - directed/random bench with behavioural AES-128 round and reference models
module tb_aes128_round_sequencer;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready, busy, err;
  logic         rnd_i_en, rnd_skip_mix_cols, rnd_o_en;
  logic [3:0]   round_idx;
  logic [127:0] plaintext, cipher_key, ciphertext, rnd_data_in, rnd_key, rnd_data_out;

  aes128_round_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .cipher_key(cipher_key), .out_valid(out_valid),
    .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy), .err(err),
    .round_idx(round_idx), .rnd_data_in(rnd_data_in), .rnd_key(rnd_key),
    .rnd_i_en(rnd_i_en), .rnd_skip_mix_cols(rnd_skip_mix_cols),
    .rnd_data_out(rnd_data_out), .rnd_o_en(rnd_o_en)
  );

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int vectors = 0, miscompares = 0;
  logic [7:0] sbox [256];

  // external round model state
  int           cd = 0, issues = 0, lat_sum = 0, skip_bad = 0, errs = 0, lat;
  bit           no_respond = 0, spur = 0, fire;
  logic [127:0] pend, first_din, first_key;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input bit last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] m [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) b[rw + 4*c] = a[rw + 4*((c + rw) % 4)];
    for (int c = 0; c < 4; c++) begin
      m[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
      m[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = last ? b[i] : m[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] s;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) s = aes_round(s, {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}, r == 10);
    return s;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: advance to the falling edge, then play the external round datapath
  task automatic tick();
    @(negedge clk);
    fire = 1'b0;
    if (rst) cd = 0;
    else begin
      if (cd > 0) begin
        cd--;
        fire = (cd == 0);
      end
      if (rnd_i_en) begin
        issues++;
        if (issues == 1) begin
          first_din = rnd_data_in;
          first_key = rnd_key;
        end
        if (rnd_skip_mix_cols !== (issues == 10)) skip_bad++;
        pend = aes_round(rnd_data_in, rnd_key, issues == 10);
        lat = $urandom_range(1, 4);
        lat_sum += lat;
        if (!no_respond) cd = lat;
      end
      if (rnd_skip_mix_cols && round_idx != 4'd10) skip_bad++;
    end
    rnd_o_en     = fire | spur;
    rnd_data_out = fire ? pend : {$urandom, $urandom, $urandom, $urandom};
    if (err) errs++;
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp,
                           input int hold, input bit spur_kg, input string tag);
    int n;
    logic [127:0] ct0;
    issues = 0; lat_sum = 0; skip_bad = 0;
    plaintext = pt; cipher_key = key; out_ready = 1'b0;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    if (spur_kg) begin
      check({tag, "_kg_round_idx"}, round_idx, 4'd1);
      rnd_o_en = 1'b1;
      tick();
      n++;
      check({tag, "_kg_spur_issue"}, {rnd_i_en, round_idx}, {1'b1, 4'd1});
    end
    while (!out_valid && n < 1000) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 1 + 20 + lat_sum);
    check({tag, "_ciphertext"}, ciphertext, exp);
    check({tag, "_i_en_pulses"}, issues, 10);
    check({tag, "_skip_mix_cols"}, skip_bad, 0);
    ct0 = ciphertext;
    in_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold"}, {out_valid, in_ready, ciphertext}, {1'b1, 1'b0, ct0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_after"}, {in_ready, out_valid, busy, round_idx}, {3'b100, 4'd0});
  endtask

  initial begin
    logic [7:0]   p, q, x;
    logic [127:0] rpt, rkey;
    int           n, first_err, ov;

    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
      sbox[p] = x;
    end while (p != 8'h01);
    sbox[0] = 8'h63;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rnd_o_en = 1'b0; rnd_data_out = '0;
    plaintext = '0; cipher_key = '0;
    repeat (3) tick();
    check("reset_ctrl", {in_ready, busy, out_valid, err, rnd_i_en, rnd_skip_mix_cols}, 6'b100000);
    check("reset_round_idx", round_idx, 4'd0);
    check("reset_ciphertext", ciphertext, 128'h0);
    check("reset_rnd_data_in", rnd_data_in, 128'h0);
    check("reset_rnd_key", rnd_key, 128'h0);
    rst = 1'b0;
    tick();
    check("post_reset_idle", {in_ready, busy, round_idx}, {2'b10, 4'd0});

    // spurious round completion while idle
    spur = 1'b1;
    rnd_o_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("spur_idle", {in_ready, busy, out_valid, round_idx}, {3'b100, 4'd0});
    end
    spur = 1'b0;
    tick();

    run_block(B_PT, B_KEY, B_CT, 20, 1'b1, "appB");
    check("appB_first_data_in", first_din, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("appB_first_key", first_key, 128'ha0fafe1788542cb123a339392a6c7605);

    run_block(C_PT, C_KEY, C_CT, 0, 1'b0, "c1");

    for (int v = 0; v < 5; v++) begin
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_block(rpt, rkey, ref_encrypt(rpt, rkey), $urandom_range(0, 3), v[0], "rand");
    end

    // round datapath never answers
    no_respond = 1'b1; issues = 0; errs = 0;
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!rnd_i_en && n < 20) begin
      tick();
      n++;
    end
    check("to_issue_seen", rnd_i_en, 1'b1);
    first_err = -1; ov = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (out_valid) ov++;
      if (err && first_err < 0) begin
        first_err = k;
        check("to_state_idle", {in_ready, busy, round_idx}, {2'b10, 4'd0});
      end
    end
    check("to_err_delay", first_err, 65);
    check("to_err_count", errs, 1);
    check("to_no_output", ov, 0);
    check("to_single_issue", issues, 1);
    no_respond = 1'b0;

    // reset during round 5 WAIT
    issues = 0;
    plaintext = B_PT; cipher_key = B_KEY;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!(rnd_i_en && round_idx == 4'd5) && n < 500) begin
      tick();
      n++;
    end
    check("rst_reach_round5", {rnd_i_en, round_idx}, {1'b1, 4'd5});
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_op", {busy, in_ready, rnd_i_en, out_valid, round_idx}, {4'b0100, 4'd0});
    rst = 1'b0;
    repeat (10) tick();
    run_block(B_PT, B_KEY, B_CT, 2, 1'b0, "appB_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
